// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// ------------
// Execution controller for the MIPS core. The core runs on the single system
// clock and advances one instruction per cpu_ce pulse. This block produces
// those pulses and steps the core through four modes: halt, free-run,
// single-step and breakpoint. A slide switch and a push button drive the modes.
//
// Build option:
//   CPU_BREAKPOINT_EN - when defined, RUN compares pc against bp_addr on each
//                       prescaler tick and enters BREAK on a match. When it is
//                       not defined, no comparator is built, BREAK cannot be
//                       reached and bp_hit is tied low.
//
// Parameters:
//   DIV - CE prescaler period in clk cycles (>= 2)
//   DEB - step button debounce interval in clk cycles (>= 2)
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active high
//   run_sw   in   raw slide switch, 1 requests free-run
//   step_btn in   raw push button, 1 = pressed
//   pc       in   current core PC (breakpoint compare)
//   bp_addr  in   breakpoint address
//   cpu_ce   out  registered one-cycle clock enable for the core
//   state    out  HALT=00 RUN=01 STEP=10 BREAK=11
//   bp_hit   out  high while state is BREAK
//   cycles   out  number of cpu_ce pulses issued (wraps, cleared by rst only)

module cpu_run_ctrl #(
    parameter int DIV = 249999,
    parameter int DEB = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic        bp_hit,
    output logic [31:0] cycles
);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEB - 1);

    // ------------------------------------------------------------------
    // Input synchronizers (2-FF each, bit 1 is the synchronized value)
    // ------------------------------------------------------------------
    logic [1:0] run_sync;
    logic [1:0] btn_sync;
    logic       run_s;
    logic       btn_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync <= '0;
            btn_sync <= '0;
        end else begin
            run_sync <= {run_sync[0], run_sw};
            btn_sync <= {btn_sync[0], step_btn};
        end
    end

    assign run_s = run_sync[1];
    assign btn_s = btn_sync[1];

    // ------------------------------------------------------------------
    // Step button debounce. dcnt counts consecutive cycles in which the
    // synchronized button disagrees with the debounced level. Any cycle of
    // agreement restarts the count. The DEB-th disagreeing cycle flips btn_db.
    // ------------------------------------------------------------------
    logic [DW-1:0] dcnt;
    logic          btn_db;
    logic          btn_db_q;
    logic          step_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt   <= '0;
            btn_db <= 1'b0;
        end else if (btn_s == btn_db) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_MAX) begin
            btn_db <= btn_s;
            dcnt   <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_db_q <= 1'b0;
        else     btn_db_q <= btn_db;
    end

    // One-cycle pulse on each press edge of the debounced button
    assign step_ev = btn_db & ~btn_db_q;

    // ------------------------------------------------------------------
    // Free-running CE prescaler. It does not depend on state, so the pulse
    // phase stays fixed relative to reset whatever mode the core is in.
    // ------------------------------------------------------------------
    logic [PW-1:0] pcnt;
    logic          tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   pcnt <= '0;
        else if (pcnt == PCNT_MAX) pcnt <= '0;
        else                       pcnt <= pcnt + 1'b1;
    end

    assign tick = (pcnt == PCNT_MAX);

`ifndef CPU_BREAKPOINT_EN
    // Compare inputs are not used in this build
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr};
`endif

    // ------------------------------------------------------------------
    // Mode FSM. cpu_ce, cycles and bp_hit are registered alongside the
    // state, so a tick in cycle t shows both the pulse and the new state at
    // t+1. cpu_ce defaults low every cycle, which keeps each pulse one cycle
    // wide.
    // ------------------------------------------------------------------
    state_t      st;
    logic [31:0] ce_count;
`ifdef CPU_BREAKPOINT_EN
    logic        bp_hit_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_HALT;
            cpu_ce   <= 1'b0;
            ce_count <= '0;
`ifdef CPU_BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
        end else begin
            cpu_ce <= 1'b0;
            case (st)
                S_HALT: begin
                    // A switch change outranks a press that lands in the same cycle
                    if (run_s)        st <= S_RUN;
                    else if (step_ev) st <= S_STEP;
                end
                S_RUN: begin
                    // Dropping the switch wins over a tick in the same cycle
                    if (!run_s) begin
                        st <= S_HALT;
                    end else if (tick) begin
`ifdef CPU_BREAKPOINT_EN
                        if (pc == bp_addr) begin
                            st       <= S_BREAK;
                            bp_hit_q <= 1'b1;
                        end else begin
                            cpu_ce   <= 1'b1;
                            ce_count <= ce_count + 32'd1;
                        end
`else
                        cpu_ce   <= 1'b1;
                        ce_count <= ce_count + 32'd1;
`endif
                    end
                end
                S_STEP: begin
                    // Exactly one pulse with no breakpoint check, so a step
                    // can move the core off a breakpoint address
                    if (tick) begin
                        cpu_ce   <= 1'b1;
                        ce_count <= ce_count + 32'd1;
                        st       <= run_s ? S_RUN : S_HALT;
                    end
                end
`ifdef CPU_BREAKPOINT_EN
                S_BREAK: begin
                    if (!run_s) begin
                        st       <= S_HALT;
                        bp_hit_q <= 1'b0;
                    end else if (step_ev) begin
                        st       <= S_STEP;
                        bp_hit_q <= 1'b0;
                    end
                end
`endif
                default: st <= S_HALT;
            endcase
        end
    end

    assign state  = st;
    assign cycles = ce_count;
`ifdef CPU_BREAKPOINT_EN
    assign bp_hit = bp_hit_q;
`else
    assign bp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with DIV=4 and DEB=3. Stimulus pushes the expected
// content of every cpu_ce pulse into a queue. The monitor pops one entry per
// pulse it sees and compares the pulse against it.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam logic [1:0] ST_HALT = 2'b00, ST_RUN = 2'b01, ST_BRK = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] bp_addr = '0;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        bp_hit;
    logic [31:0] cycles;

    cpu_run_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
        .pc(pc), .bp_addr(bp_addr), .cpu_ce(cpu_ce), .state(state),
        .bp_hit(bp_hit), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cyc;
        logic [1:0]  st;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ncyc;          // clock edges since reset release
    logic [31:0] cnt_m;         // reference count of pulses issued
    logic        prev_ce = 1'b0;
    bit          saw_step = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: every issued pulse bumps the count by one and carries the
    // state the core is left in.
    task automatic expect_ce(input logic [1:0] st);
        exp_t e;
        cnt_m = cnt_m + 32'd1;
        e.cyc = cnt_m;
        e.st  = st;
        exp_q.push_back(e);
    endtask

    always @(posedge clk or posedge rst)
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_ce = 1'b0;
        end else begin
            if (state == 2'b10) saw_step = 1'b1;
            chk("bp_hit_vs_state", {31'b0, bp_hit}, {31'b0, state == ST_BRK});
            if (cpu_ce) begin
                chk("ce_width", {31'b0, prev_ce}, 32'd0);
                chk("ce_phase", ncyc % DIV, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ce: got pulse at cycle %0d cycles=0x%08h expected none", ncyc, cycles);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ce_cycles", cycles, e.cyc);
                    chk("ce_state", {30'b0, state}, {30'b0, e.st});
                end
            end
            prev_ce = cpu_ce;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pulses missing after %0d cycles expected 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_state(input string name, input logic [1:0] st, input int budget);
        int k = 0;
        while (state !== st && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, {30'b0, state}, {30'b0, st});
    endtask

    task automatic press(input int hold);
        step_btn = 1'b1;
        tick_n(hold);
        step_btn = 1'b0;
    endtask

    function automatic logic [31:0] rand_nonmatch(input logic [31:0] a);
        return a ^ ($urandom() | 32'd1);
    endfunction

    initial begin
        int k;
        cnt_m   = '0;
        bp_addr = $urandom();
        pc      = rand_nonmatch(bp_addr);

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_ce", {31'b0, cpu_ce}, 32'd0);
        chk("rst_state",  {30'b0, state},  32'd0);
        chk("rst_bp_hit", {31'b0, bp_hit}, 32'd0);
        chk("rst_cycles", cycles, 32'd0);

        // Free run from reset
        run_sw = 1'b1;
        rst    = 1'b0;
        for (int i = 0; i < 5; i++) expect_ce(ST_RUN);
        tick_n(3);
        chk("run_within_3", {30'b0, state}, {30'b0, ST_RUN});
        drain("run_5_pulses", 40);
        chk("cycles_after_5", cycles, 32'd5);

        // Switch drops so that run_s falls in a tick cycle: no pulse, HALT
        tick_n(1);
        run_sw = 1'b0;
        wait_state("halt_on_tick_drop", ST_HALT, 8);
        tick_n(2 * DIV);
        chk("halt_cycles", cycles, cnt_m);

        // Two clean step presses
        for (int p = 0; p < 2; p++) begin
            expect_ce(ST_HALT);
            press((p == 0) ? 10 : int'($urandom_range(8, 14)));
            drain("step_press", 30);
            tick_n(DEB + 6);
            chk("step_back_halt", {30'b0, state}, {30'b0, ST_HALT});
            chk("step_cycles", cycles, cnt_m);
        end

        // Bouncing button: toggling, then random short bursts
        for (int i = 0; i < 20; i++) begin
            step_btn = ~step_btn;
            tick_n(1);
        end
        step_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_btn = 1'b1;
            tick_n($urandom_range(1, DEB - 1));
            step_btn = 1'b0;
            tick_n($urandom_range(1, DEB - 1));
        end
        tick_n(20);
        chk("bounce_state", {30'b0, state}, {30'b0, ST_HALT});
        chk("bounce_cycles", cycles, cnt_m);

        // Breakpoint
        bp_addr = 32'h0000_0010;
        pc      = rand_nonmatch(bp_addr);
        run_sw  = 1'b1;
        expect_ce(ST_RUN);
        expect_ce(ST_RUN);
        drain("resume_run", 40);
        pc = 32'h0000_0010;
`ifdef CPU_BREAKPOINT_EN
        wait_state("enter_break", ST_BRK, 2 * DIV);
        chk("break_phase", ncyc % DIV, 32'd0);
        chk("break_bp_hit", {31'b0, bp_hit}, 32'd1);
        chk("break_no_ce", cycles, cnt_m);
        tick_n(3 * DIV);
        chk("break_holds", {30'b0, state}, {30'b0, ST_BRK});
        saw_step = 1'b0;
        expect_ce(ST_RUN);
        step_btn = 1'b1;
        drain("break_step", 30);
        pc = rand_nonmatch(bp_addr);
        expect_ce(ST_RUN);
        chk("break_via_step", {31'b0, saw_step}, 32'd1);
        chk("step_back_run", {30'b0, state}, {30'b0, ST_RUN});
        step_btn = 1'b0;
        drain("run_after_step", 3 * DIV + 2);
`else
        expect_ce(ST_RUN);
        drain("no_bp_run", 3 * DIV + 2);
        chk("no_bp_hit", {31'b0, bp_hit}, 32'd0);
`endif

        // Counter wrap
        run_sw = 1'b0;
        wait_state("halt_before_wrap", ST_HALT, 8);
        force dut.ce_count = 32'hFFFF_FFFE;
        tick_n(1);
        release dut.ce_count;
        tick_n(1);
        cnt_m = 32'hFFFF_FFFE;
        chk("preload", cycles, cnt_m);
        run_sw = 1'b1;
        expect_ce(ST_RUN);
        expect_ce(ST_RUN);
        drain("wrap", 40);
        chk("wrapped", cycles, 32'd0);

        // Asynchronous reset in the middle of a pulse
        k = 0;
        @(posedge clk); #1;
        while (!cpu_ce && k < 3 * DIV) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_pulse_ce", {31'b0, cpu_ce}, 32'd1);
        chk("mid_pulse_cycles", cycles, cnt_m + 32'd1);
        rst = 1'b1;
        #1;
        chk("async_cpu_ce", {31'b0, cpu_ce}, 32'd0);
        chk("async_state",  {30'b0, state},  32'd0);
        chk("async_bp_hit", {31'b0, bp_hit}, 32'd0);
        chk("async_cycles", cycles, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        tick_n(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Execution controller for the MIPS core. It replaces free-running divided CPU clocks with a single system clock plus a one-cycle clock-enable pulse, `cpu_ce`. It sequences the core through halt, free-run, single-step and breakpoint modes, driven by a board switch and a push button. It sits between the board I/O and the core, and its `cycles` output can be routed to the 7-segment display path.

## Interface
Parameters:
- `DIV`, default 249999: CE prescaler period in `clk` cycles (≥2).
- `DEB`, default 500000: step-button debounce interval in `clk` cycles (≥2).

Ports:
- `clk` in 1: system clock; every register in the block uses it.
- `rst` in 1: reset, asynchronous, active-high.
- `run_sw` in 1: raw slide switch; 1 requests free-run.
- `step_btn` in 1: raw push button; 1 = pressed.
- `pc` in 32: current core PC, used for breakpoint compare.
- `bp_addr` in 32: breakpoint address.
- `cpu_ce` out 1: registered one-`clk` pulse; the core advances one instruction per pulse.
- `state` out 2: HALT=00, RUN=01, STEP=10, BREAK=11.
- `bp_hit` out 1: 1 while `state`==BREAK.
- `cycles` out 32: count of issued `cpu_ce` pulses.

## Operation
Input conditioning:
- `run_sw` and `step_btn` each pass through a 2-FF synchronizer, giving `run_s` and `btn_s`.
- Debounce: `btn_db` takes `btn_s` only after `btn_s` has differed from `btn_db` for `DEB` consecutive cycles. Any bounce back restarts the counter.
- `step_ev` is a one-cycle pulse on each 0→1 transition of `btn_db`.

Prescaler:
- Counter `pcnt` runs 0..DIV-1 and wraps.
- `tick`=1 when `pcnt`==DIV-1. It is free-running and independent of state.

FSM (reset → HALT):
- HALT
  - `run_s`=1 → RUN.
  - Otherwise `step_ev` → STEP.
- RUN
  - `run_s`=0 → HALT; takes priority over the tick.
  - `tick` and breakpoint match → BREAK, with no CE issued.
  - `tick` without a match → issue CE and stay in RUN.
- STEP
  - Waits for `tick`, then issues exactly one CE. No breakpoint check is made on this CE.
  - Next state is RUN if `run_s`=1, else HALT.
- BREAK
  - `run_s`=0 → HALT.
  - `step_ev` → STEP. With `run_s`=1 this resumes free-run after the single step.
- `step_ev` is ignored in RUN and STEP; it is not queued.

Breakpoint match: `pc`==`bp_addr`, full 32-bit equality, sampled in the tick cycle.

CE and counter:
- "Issue CE" sets `cpu_ce`=1 in the cycle after the tick.
- `cycles` increments by 1 in the same cycle `cpu_ce`=1.
- `cycles` wraps 0xFFFFFFFF→0 and is cleared only by `rst`.

## Timing
- Reset values:
  - Outputs: `cpu_ce`=0, `state`=00, `bp_hit`=0, `cycles`=0.
  - Internal: `pcnt`=0, synchronizers=0, `btn_db`=0, debounce counter=0.
- `cpu_ce` is exactly one `clk` wide, with at most one pulse per `DIV` cycles.
- Tick at cycle t gives `cpu_ce`=1 at t+1. The state transition caused by the tick is also visible at t+1.
- Step latency from a clean press: 2 (sync) + `DEB` (debounce) + 1 (edge) cycles to `step_ev`, plus 0..DIV-1 cycles waiting for the tick, plus 1 cycle to `cpu_ce`.
- `run_s` falling in the same cycle as a tick in RUN: no CE; next state is HALT.
- `step_ev` and `run_s` rising in the same cycle in HALT: RUN wins and the step is dropped.
- Asserting `rst` mid-pulse clears `cpu_ce` immediately, since reset is asynchronous.

## Configuration
- `CPU_BREAKPOINT_EN` defined: breakpoint compare is active, BREAK is reachable, and `bp_hit` behaves as specified.
- Not defined:
  - No comparator is built; `pc` and `bp_addr` are unused.
  - BREAK is unreachable and `bp_hit` is tied to 0.
  - RUN issues a CE on every tick.

## Test plan
Bench parameters: `DIV`=4, `DEB`=3, `CPU_BREAKPOINT_EN` defined.
- Reset then `run_sw`=1 held → `state`=01 within 3 cycles. `cpu_ce` pulses every 4 cycles, each 1 cycle wide. `cycles` reads 5 after the fifth pulse.
- `run_sw`=0, clean `step_btn` press held 10 cycles → exactly one `cpu_ce`, `cycles` +1, `state` returns to 00. A second press yields one more pulse.
- `step_btn` toggling every cycle for 20 cycles, then 0 → no `step_ev`, no `cpu_ce`, `state` stays 00.
- `run_sw`=1, `bp_addr`=0x00000010, `pc` driven to 0x10 → on the next tick `state`=11, `bp_hit`=1, no CE. A step press gives one CE, `state` passes through STEP and returns to 01.
- `run_sw`=1 with `cycles` forced near 0xFFFFFFFE, two pulses → `cycles`=0x00000000. Assert `rst` asynchronously during `cpu_ce`=1 → all outputs at reset values in the same cycle.
